// File: rtl/decode_stage.sv
// Decode stage: field split, immediate extension, registered output bundle
// behind valid/ready, and a register scoreboard for RAW/WAW stalls.
module decode_stage #(
  parameter int OPC_W       = 4,
  parameter int REG_W       = 4,
  parameter int INSTR_W     = 16,
  parameter int IMM_W       = 8,
  parameter int RTYPE_LIMIT = 5,
  parameter int BEQ_OPC     = 5,
  parameter int LOAD_OPC    = 6,
  parameter int STORE_OPC   = 7,
  parameter int SIGN_EXT    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   read_reg1,
  output logic [REG_W-1:0]   read_reg2,
  output logic [REG_W-1:0]   write_reg,
  output logic [IMM_W-1:0]   immediate,
  output logic               reg_write,
  output logic               is_rtype,
  input  logic               wb_valid,
  input  logic [REG_W-1:0]   wb_reg,
  input  logic               flush,
  output logic               busy
);

  localparam int NREGS = 2**REG_W;

  if (INSTR_W != OPC_W + 3*REG_W) begin : g_bad_instr_w
    $error("INSTR_W must equal OPC_W + 3*REG_W");
  end
  if (IMM_W < REG_W) begin : g_bad_imm_w
    $error("IMM_W must be >= REG_W");
  end

  logic [OPC_W-1:0]        d_opc;
  logic [REG_W-1:0]        d_rs1;
  logic [REG_W-1:0]        d_rs2;
  logic [REG_W-1:0]        d_low;
  logic signed [REG_W-1:0] d_low_s;
  logic [REG_W-1:0]        d_wr;
  logic [IMM_W-1:0]        d_imm;
  logic                    d_rtype;
  logic                    d_beq;
  logic                    d_load;
  logic                    d_store;
  logic                    d_regw;
  logic                    d_use1;
  logic                    d_use2;

  assign d_opc   = instruction[INSTR_W-1 -: OPC_W];
  assign d_rs1   = instruction[INSTR_W-OPC_W-1 -: REG_W];
  assign d_rs2   = instruction[INSTR_W-OPC_W-REG_W-1 -: REG_W];
  assign d_low   = instruction[REG_W-1:0];
  assign d_low_s = d_low;

  assign d_rtype = int'(d_opc) < RTYPE_LIMIT;
  assign d_beq   = int'(d_opc) == BEQ_OPC;
  assign d_load  = int'(d_opc) == LOAD_OPC;
  assign d_store = int'(d_opc) == STORE_OPC;
  assign d_regw  = ~(d_beq | d_store);
  assign d_use1  = ~d_load;
  assign d_use2  = d_rtype | d_beq | d_load | d_store;
  assign d_wr    = d_rtype ? d_low : d_rs1;

  always_comb begin
    d_imm = '0;
    if (!d_rtype) begin
      if (SIGN_EXT != 0) d_imm = IMM_W'(d_low_s);
      else               d_imm = IMM_W'(d_low);
    end
  end

  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] held_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] blocked;
  logic             hazard;
  logic             accept;
  logic             issue;

  assign wb_mask   = wb_valid ? (NREGS'(1) << wb_reg) : '0;
  assign held_mask = (out_valid & reg_write) ? (NREGS'(1) << write_reg) : '0;
  // A same-cycle writeback releases the stall; the held bundle is not yet
  // in the scoreboard, so its destination blocks separately.
  assign blocked   = (sb & ~wb_mask) | held_mask;

  assign hazard = (d_use1 & blocked[d_rs1])
                | (d_use2 & blocked[d_rs2])
                | (d_regw & blocked[d_wr]);

  assign in_ready = ~rst & ~hazard & (~out_valid | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;
  assign issue    = out_valid & out_ready & ~flush;
  assign set_mask = (issue & reg_write) ? (NREGS'(1) << write_reg) : '0;
  assign busy     = |sb;

  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= (sb & ~wb_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      opcode    <= '0;
      read_reg1 <= '0;
      read_reg2 <= '0;
      write_reg <= '0;
      immediate <= '0;
      reg_write <= 1'b0;
      is_rtype  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      opcode    <= d_opc;
      read_reg1 <= d_rs1;
      read_reg2 <= d_rs2;
      write_reg <= d_wr;
      immediate <= d_imm;
      reg_write <= d_regw;
      is_rtype  <= d_rtype;
    end else if (issue) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus stall,
// back-pressure, flush and reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [3:0]  read_reg1;
  logic [3:0]  read_reg2;
  logic [3:0]  write_reg;
  logic [7:0]  immediate;
  logic        reg_write;
  logic        is_rtype;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic        flush;
  logic        busy;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [3:0]  s_opcode;
  logic [3:0]  s_rr1;
  logic [3:0]  s_rr2;
  logic [3:0]  s_wr;
  logic [7:0]  s_imm;
  logic        s_regw;
  logic        s_rtype;
  logic        s_busy;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .read_reg1(read_reg1),
    .read_reg2(read_reg2), .write_reg(write_reg),
    .immediate(immediate), .reg_write(reg_write),
    .is_rtype(is_rtype), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .busy(busy)
  );

  decode_stage #(.SIGN_EXT(1)) dut_sx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .instruction(instruction), .out_valid(s_out_valid),
    .out_ready(out_ready), .opcode(s_opcode), .read_reg1(s_rr1),
    .read_reg2(s_rr2), .write_reg(s_wr),
    .immediate(s_imm), .reg_write(s_regw),
    .is_rtype(s_rtype), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .busy(s_busy)
  );

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  opc;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  wr;
    logic [7:0]  imm;
    logic [7:0]  imm_sx;
    logic        regw;
    logic        rtype;
  } vec_t;

  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wb_valid  = 1'b0;
    wb_reg    = '0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [15:0] stream [3];
  logic [3:0]  stream_wr [3];

  initial begin
    vecs[0] = '{16'h0123, 4'h0, 4'h1, 4'h2, 4'h3, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[1] = '{16'h6A2F, 4'h6, 4'hA, 4'h2, 4'hA, 8'h0F, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{16'h7120, 4'h7, 4'h1, 4'h2, 4'h1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{16'h5348, 4'h5, 4'h3, 4'h4, 4'h3, 8'h08, 8'hF8, 1'b0, 1'b0};
    vecs[4] = '{16'h4FFF, 4'h4, 4'hF, 4'hF, 4'hF, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{16'h8007, 4'h8, 4'h0, 4'h0, 4'h0, 8'h07, 8'h07, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{16'hF9A5, 4'hF, 4'h9, 4'hA, 4'h9, 8'h05, 8'h05, 1'b1, 1'b0};

    // Reset with a valid instruction presented
    idle();
    rst = 1'b1;
    in_valid = 1'b1;
    instruction = 16'h0123;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_outputs",
          32'({out_valid, opcode, read_reg1, read_reg2, write_reg,
               immediate, reg_write, is_rtype, busy}), 32'd0);
    end
    rst = 1'b0;
    idle();

    // Decode table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      in_valid = 1'b1;
      instruction = vecs[i].instr;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].opc));
      chk($sformatf("v%0d_rr1", i), 32'(read_reg1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d_rr2", i), 32'(read_reg2), 32'(vecs[i].rs2));
      chk($sformatf("v%0d_wr", i), 32'(write_reg), 32'(vecs[i].wr));
      chk($sformatf("v%0d_imm", i), 32'(immediate), 32'(vecs[i].imm));
      chk($sformatf("v%0d_imm_sx", i), 32'(s_imm), 32'(vecs[i].imm_sx));
      chk($sformatf("v%0d_regw", i), 32'(reg_write), 32'(vecs[i].regw));
      chk($sformatf("v%0d_rtype", i), 32'(is_rtype), 32'(vecs[i].rtype));
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_issued", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].regw));
    end

    // RAW stall released by same-cycle writeback
    do_reset();
    in_valid = 1'b1;
    instruction = 16'h0123;
    out_ready = 1'b1;
    @(negedge clk);
    instruction = 16'h0345;
    #1;
    chk("raw_held_stall", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("raw_busy", 32'(busy), 32'd1);
    wb_valid = 1'b1;
    wb_reg = 4'd2;
    #1;
    chk("raw_sb_stall", 32'(in_ready), 32'd0);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("raw_wb_other_busy", 32'(busy), 32'd1);
    #1;
    chk("raw_still_stall", 32'(in_ready), 32'd0);
    wb_valid = 1'b1;
    wb_reg = 4'd3;
    #1;
    chk("raw_wb_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    wb_valid = 1'b0;
    in_valid = 1'b0;
    chk("raw_out_valid", 32'(out_valid), 32'd1);
    chk("raw_out_wr", 32'(write_reg), 32'd5);
    chk("raw_bit3_cleared", 32'(busy), 32'd0);
    @(negedge clk);
    chk("raw_bit5_set", 32'(busy), 32'd1);
    wb_valid = 1'b1;
    wb_reg = 4'd5;
    @(negedge clk);
    wb_valid = 1'b0;
    chk("raw_wb5_clear", 32'(busy), 32'd0);

    // Back-pressure, then stream three independent instructions
    do_reset();
    in_valid = 1'b1;
    instruction = 16'h0123;
    @(negedge clk);
    instruction = 16'h0456;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", 32'({out_valid, opcode, read_reg1, read_reg2, write_reg}),
          32'h10123);
      @(negedge clk);
    end
    stream[0] = 16'h0456; stream_wr[0] = 4'h6;
    stream[1] = 16'h0789; stream_wr[1] = 4'h9;
    stream[2] = 16'h0ABC; stream_wr[2] = 4'hC;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instruction = stream[k];
      #1;
      chk($sformatf("st%0d_in_ready", k), 32'(in_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("st%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("st%0d_wr", k), 32'(write_reg), 32'(stream_wr[k]));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("st_drained", 32'(out_valid), 32'd0);
    chk("st_busy", 32'(busy), 32'd1);

    // Store issues without touching the scoreboard
    do_reset();
    in_valid = 1'b1;
    instruction = 16'h0123;
    out_ready = 1'b1;
    @(negedge clk);
    instruction = 16'h7120;
    #1;
    chk("store_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("store_regw", 32'(reg_write), 32'd0);
    chk("store_busy", 32'(busy), 32'd1);
    @(negedge clk);
    wb_valid = 1'b1;
    wb_reg = 4'd3;
    @(negedge clk);
    wb_valid = 1'b0;
    chk("store_no_bit", 32'(busy), 32'd0);

    // Flush beats out_ready
    do_reset();
    in_valid = 1'b1;
    instruction = 16'h0123;
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);

    // Reset in the middle of a stall
    do_reset();
    in_valid = 1'b1;
    instruction = 16'h0123;
    out_ready = 1'b1;
    @(negedge clk);
    instruction = 16'h0345;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    idle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined, parametrised instruction decode stage between instruction fetch and register-file read / ALU.
- Splits each instruction into opcode, source registers, destination register and extended immediate.
- Registers the result behind a valid/ready handshake.
- Tracks in-flight register writes in a scoreboard and stalls read-after-write and write-after-write hazards until writeback.

Parameters:
- OPC_W, 4: opcode field width.
- REG_W, 4: register index width; NREGS = 2**REG_W.
- INSTR_W, 16: instruction width; must equal OPC_W + 3*REG_W (elaboration error otherwise).
- IMM_W, 8: extended immediate width; must be >= REG_W.
- RTYPE_LIMIT, 5: opcodes strictly below this are R-type; all others are I-type.
- BEQ_OPC, 5: branch opcode.
- LOAD_OPC, 6: load opcode.
- STORE_OPC, 7: store opcode.
- SIGN_EXT, 0: 0 zero-extends the immediate; 1 sign-extends it.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: fetch presents an instruction.
- in_ready, output, 1: decode accepts this cycle.
- instruction, input, INSTR_W: raw instruction.
- out_valid, output, 1: decoded bundle valid.
- out_ready, input, 1: downstream accepts (issue).
- opcode, output, OPC_W: decoded opcode.
- read_reg1, output, REG_W: source 1 (field [INSTR_W-OPC_W-1 -: REG_W]).
- read_reg2, output, REG_W: source 2 (next REG_W field down).
- write_reg, output, REG_W: destination.
- immediate, output, IMM_W: extended immediate (bits [REG_W-1:0]).
- reg_write, output, 1: instruction writes write_reg.
- is_rtype, output, 1: opcode < RTYPE_LIMIT.
- wb_valid, input, 1: writeback completes this cycle.
- wb_reg, input, REG_W: register being written back.
- flush, input, 1: discard the un-issued output bundle.
- busy, output, 1: OR of all scoreboard bits.

Behaviour:
- **Field rules**
  - R-type: write_reg = low REG_W bits; immediate = 0.
  - I-type: write_reg = read_reg1 field; immediate = low REG_W bits, zero- or sign-extended to IMM_W.
- **reg_write**: 1 for all opcodes except BEQ_OPC and STORE_OPC.
- **Source usage (for hazard checks only)**
  - uses_rs1 = every opcode except LOAD_OPC.
  - uses_rs2 = R-type, BEQ, LOAD or STORE.
- **Scoreboard**
  - NREGS bits.
  - Bit set on issue (out_valid & out_ready) when reg_write = 1.
  - Bit cleared when wb_valid targets it.
  - Same-cycle set and clear of the same bit: set wins.
- **Hazard (combinational on incoming instruction)**
  - Effective pending = scoreboard & ~(wb_valid ? onehot(wb_reg) : 0); same-cycle writeback releases the stall.
  - Hazard = a used source, or write_reg when reg_write, hits effective pending.
  - Also a hazard if it hits the held bundle's write_reg while out_valid & reg_write.
- **in_ready** = ~rst & ~hazard & (~out_valid | out_ready) & ~flush.
- **Output register**
  - Loads on in_valid & in_ready.
  - Latency 1 cycle: bundle appears with out_valid the cycle after acceptance.
  - Throughput 1/cycle with no hazard.
  - Held stable while out_valid & ~out_ready.
  - out_valid clears on issue with no new accept.
- **flush**
  - Clears out_valid next cycle; no accept that cycle.
  - Scoreboard untouched; flushed bundle was never issued, so it sets no bit.
  - flush and out_ready in the same cycle: flush wins, no issue, no scoreboard set.
- **Reset**
  - out_valid = 0; opcode, read_reg1, read_reg2, write_reg, immediate, reg_write, is_rtype = 0.
  - Scoreboard = 0, busy = 0, in_ready = 0 during reset.
  - Reset mid-stall drops the held bundle and all pending bits.
- **Boundaries**
  - wb_valid for a register not pending: no effect.
  - Register 0 has no special treatment.
  - Sign extension with immediate MSB = 1 fills upper IMM_W-REG_W bits with 1.

Test Plan:
- **Reset state**: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, all outputs 0, busy=0.
- **R-type decode**: instruction 0x0123, out_ready=1 -> next cycle opcode=0, read_reg1=1, read_reg2=2, write_reg=3, immediate=0x00, reg_write=1, is_rtype=1; after issue, busy=1 with scoreboard bit 3 set.
- **Load immediate extension**: 0x6A2F, SIGN_EXT=0 -> write_reg=10, read_reg2=2, immediate=0x0F, reg_write=1. Same with SIGN_EXT=1 -> immediate=0xFF.
- **RAW stall**
  - Issue 0x0123, then present 0x0345 (reads r3) -> in_ready=0 until wb_valid=1, wb_reg=3.
  - in_ready=1 in that same wb cycle; accepted; scoreboard bit 3 cleared then set again only if the new instruction writes r3.
- **Back-pressure**: out_ready=0 for 4 cycles with a valid bundle -> outputs stable, in_ready=0. Release -> streams 3 independent instructions at 1/cycle.
- **Store/branch and flush**
  - 0x7120 (STORE) issued -> reg_write=0, busy unchanged.
  - A bundle held with out_ready=0, flush=1 -> out_valid=0 next cycle, scoreboard unchanged.
